// File: rtl/ccl_equiv_resolver.sv
// rtl/ccl_equiv_resolver.sv - label allocator, double-buffered merge stacks, equivalence table
// and a multi-hop pipelined label resolver for connected-components labelling.
module ccl_equiv_resolver #(
  parameter int LABEL_W     = 8,
  parameter int STACK_DEPTH = 64,
  parameter int MAX_CHAIN   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               frame_start,
  input  logic               line_end,
  input  logic               new_label,
  output logic [LABEL_W-1:0] alloc_label,
  input  logic               merge_valid,
  input  logic [LABEL_W-1:0] merge_min,
  input  logic [LABEL_W-1:0] merge_max,
  input  logic               lookup_valid,
  input  logic [LABEL_W-1:0] lookup_label,
  output logic               resolved_valid,
  output logic [LABEL_W-1:0] resolved_label,
  output logic [LABEL_W-1:0] num_labels,
  output logic               overflow,
  output logic               stack_full,
  output logic               flush_busy
);
  localparam int NLAB  = 1 << LABEL_W;
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [LABEL_W-1:0] LMAX    = {LABEL_W{1'b1}};
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(STACK_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WRITE} drain_state_e;

  logic [LABEL_W-1:0]   table_q [NLAB];
  logic [2*LABEL_W-1:0] stack_mem [2][STACK_DEPTH];
  logic [CNT_W-1:0]     cnt_q [2];
  logic                 sel_q;
  logic                 swap_pending_q;
  drain_state_e         state_q;
  logic [LABEL_W-1:0]   max_q;
  logic [LABEL_W-1:0]   r_q;
  logic [LABEL_W-1:0]   num_q;
  logic                 overflow_q;
  logic                 stack_full_q;
  logic [LABEL_W-1:0]   lbl_q [MAX_CHAIN];
  logic [MAX_CHAIN-1:0] vld_q;

  logic                 drn;
  logic                 alloc_ok;
  logic                 merge_ok;
  logic                 push_ok;
  logic                 busy;
  logic [PTR_W-1:0]     push_ptr;
  logic [PTR_W-1:0]     top_ptr;
  logic [2*LABEL_W-1:0] top;

  assign drn         = ~sel_q;
  assign alloc_ok    = new_label && en && (num_q != LMAX);
  assign alloc_label = alloc_ok ? num_q : '0;
  assign merge_ok    = merge_valid && (merge_min != '0) && (merge_min < merge_max);
  assign push_ok     = en && !frame_start && merge_ok && (cnt_q[sel_q] != DEPTH_C);
  assign busy        = (cnt_q[drn] != '0) || (state_q != IDLE);
  assign push_ptr    = PTR_W'(cnt_q[sel_q]);
  assign top_ptr     = PTR_W'(cnt_q[drn] - 1'b1);
  assign top         = stack_mem[drn][top_ptr];

  assign num_labels     = num_q;
  assign overflow       = overflow_q;
  assign stack_full     = stack_full_q;
  assign flush_busy     = busy;
  assign resolved_valid = vld_q[MAX_CHAIN-1];
  assign resolved_label = lbl_q[MAX_CHAIN-1];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[sel_q][push_ptr] <= {merge_max, merge_min};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NLAB; i++) table_q[i] <= LABEL_W'(i);
      for (int k = 0; k < MAX_CHAIN; k++) lbl_q[k] <= '0;
      cnt_q[0]       <= '0;
      cnt_q[1]       <= '0;
      sel_q          <= 1'b0;
      swap_pending_q <= 1'b0;
      state_q        <= IDLE;
      max_q          <= '0;
      r_q            <= '0;
      num_q          <= LABEL_W'(1);
      overflow_q     <= 1'b0;
      stack_full_q   <= 1'b0;
      vld_q          <= '0;
    end else if (en) begin
      if (frame_start) begin
        for (int i = 0; i < NLAB; i++) table_q[i] <= LABEL_W'(i);
        for (int k = 0; k < MAX_CHAIN; k++) lbl_q[k] <= '0;
        cnt_q[0]       <= '0;
        cnt_q[1]       <= '0;
        sel_q          <= 1'b0;
        swap_pending_q <= 1'b0;
        state_q        <= IDLE;
        max_q          <= '0;
        r_q            <= '0;
        num_q          <= LABEL_W'(1);
        overflow_q     <= 1'b0;
        stack_full_q   <= 1'b0;
        vld_q          <= '0;
      end else begin
        if (new_label) begin
          if (num_q != LMAX) begin
            table_q[num_q] <= num_q;
            num_q          <= num_q + 1'b1;
          end else begin
            overflow_q <= 1'b1;
          end
        end

        if (merge_ok) begin
          if (cnt_q[sel_q] != DEPTH_C) cnt_q[sel_q] <= cnt_q[sel_q] + 1'b1;
          else                         stack_full_q <= 1'b1;
        end

        // A swap only happens with the drain side empty, so it never races a pop.
        if ((line_end || swap_pending_q) && !busy) begin
          sel_q          <= ~sel_q;
          swap_pending_q <= 1'b0;
        end else if (line_end) begin
          swap_pending_q <= 1'b1;
        end

        case (state_q)
          IDLE: begin
            if (cnt_q[drn] != '0) begin
              max_q       <= top[2*LABEL_W-1:LABEL_W];
              r_q         <= table_q[top[LABEL_W-1:0]];
              cnt_q[drn]  <= cnt_q[drn] - 1'b1;
              state_q     <= READ;
            end
          end
          READ:  state_q <= WRITE;
          WRITE: begin
            // Allocation owns the single table write port; the drain waits a cycle.
            if (!new_label) begin
              table_q[max_q] <= r_q;
              state_q        <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase

        // The first hop reads the request directly so MAX_CHAIN hops take MAX_CHAIN cycles.
        vld_q[0] <= lookup_valid;
        lbl_q[0] <= table_q[lookup_label];
        for (int k = 1; k < MAX_CHAIN; k++) begin
          vld_q[k] <= vld_q[k-1];
          lbl_q[k] <= table_q[lbl_q[k-1]];
        end
      end
    end
  end

endmodule

// File: tb/tb_ccl_equiv_resolver.sv
// tb/tb_ccl_equiv_resolver.sv - directed self-checking bench for ccl_equiv_resolver.
module tb_ccl_equiv_resolver;
  localparam int LW = 3;
  localparam int SD = 4;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          reset_n, en, frame_start, line_end, new_label;
  logic          merge_valid, lookup_valid;
  logic [LW-1:0] merge_min, merge_max, lookup_label;
  logic [LW-1:0] alloc_label, resolved_label, num_labels;
  logic          resolved_valid, overflow, stack_full, flush_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ccl_equiv_resolver #(.LABEL_W(LW), .STACK_DEPTH(SD), .MAX_CHAIN(MC)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .frame_start(frame_start),
    .line_end(line_end), .new_label(new_label), .alloc_label(alloc_label),
    .merge_valid(merge_valid), .merge_min(merge_min), .merge_max(merge_max),
    .lookup_valid(lookup_valid), .lookup_label(lookup_label),
    .resolved_valid(resolved_valid), .resolved_label(resolved_label),
    .num_labels(num_labels), .overflow(overflow), .stack_full(stack_full),
    .flush_busy(flush_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic alloc(input logic [LW-1:0] exp, input string tag);
    new_label = 1'b1;
    #1;
    check_eq(tag, alloc_label, exp);
    @(posedge clk);
    #1;
    new_label = 1'b0;
  endtask

  task automatic merge(input logic [LW-1:0] mn, input logic [LW-1:0] mx);
    merge_valid = 1'b1;
    merge_min   = mn;
    merge_max   = mx;
    tick();
    merge_valid = 1'b0;
    merge_min   = '0;
    merge_max   = '0;
  endtask

  task automatic line();
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (flush_busy && n < 60) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    count_busy(n);
    check_eq({tag, "_drained"}, flush_busy, 0);
  endtask

  task automatic lookup(input logic [LW-1:0] lbl, input logic [LW-1:0] exp, input string tag);
    lookup_valid = 1'b1;
    lookup_label = lbl;
    tick();
    lookup_valid = 1'b0;
    lookup_label = '0;
    repeat (MC - 2) tick();
    check_eq({tag, "_early"}, resolved_valid, 0);
    tick();
    check_eq({tag, "_vld"}, resolved_valid, 1);
    check_eq(tag, resolved_label, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int m;
    reset_n = 1'b0; en = 1'b1; frame_start = 1'b0; line_end = 1'b0; new_label = 1'b0;
    merge_valid = 1'b0; merge_min = '0; merge_max = '0;
    lookup_valid = 1'b0; lookup_label = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_num", num_labels, 1);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_sfull", stack_full, 0);
    check_eq("rst_rvld", resolved_valid, 0);
    check_eq("rst_rlbl", resolved_label, 0);
    check_eq("rst_busy", flush_busy, 0);
    check_eq("rst_alloc", alloc_label, 0);
    reset_n = 1'b1;
    tick();

    // Basic allocation and identity lookup
    for (int i = 1; i <= 3; i++) alloc(LW'(i), "alloc_basic");
    check_eq("num_after3", num_labels, 4);
    lookup(2, 2, "lookup_2");
    lookup(0, 0, "lookup_bg");

    // Allocation saturation and frame clear
    frame();
    check_eq("frame_num", num_labels, 1);
    for (int i = 1; i <= 8; i++) alloc((i < 7) ? LW'(i) : LW'(0), "alloc_sat");
    check_eq("sat_ovf", overflow, 1);
    check_eq("sat_num", num_labels, 7);
    frame();
    check_eq("clr_ovf", overflow, 0);
    check_eq("clr_num", num_labels, 1);

    // Two merges in one line, LIFO drain order
    for (int i = 1; i <= 3; i++) alloc(LW'(i), "alloc_m");
    merge(1, 3);
    merge(2, 3);
    check_eq("busy_before_swap", flush_busy, 0);
    line();
    count_busy(n);
    check_eq("busy_cycles_2", n, 6);
    lookup(3, 1, "lookup_3_lifo");
    lookup(2, 2, "lookup_2_root");

    // Chain across three lines
    frame();
    for (int i = 1; i <= 4; i++) alloc(LW'(i), "alloc_c");
    merge(3, 4); line(); wait_drain("chain1");
    merge(2, 3); line(); wait_drain("chain2");
    merge(1, 2); line(); wait_drain("chain3");
    lookup(4, 1, "lookup_chain4");

    // Stack overflow and discarded pairs
    frame();
    merge(5, 5);
    merge(0, 3);
    check_eq("discard_no_flag", stack_full, 0);
    merge(1, 2); merge(1, 3); merge(1, 4); merge(1, 5);
    check_eq("full_not_yet", stack_full, 0);
    merge(1, 6);
    check_eq("full_flag", stack_full, 1);
    line();
    count_busy(n);
    check_eq("busy_cycles_4", n, 12);
    lookup(5, 1, "lookup_5_drained");
    lookup(2, 1, "lookup_2_drained");
    lookup(6, 6, "lookup_6_dropped");

    // Deferred swap, push during drain, allocation stalling WRITE
    frame();
    merge(1, 2);
    merge(1, 3);
    line();
    n = 0;
    if (flush_busy) n++;
    merge_valid = 1'b1; merge_min = 3; merge_max = 4; line_end = 1'b1;
    tick();
    merge_valid = 1'b0; merge_min = '0; merge_max = '0; line_end = 1'b0;
    if (flush_busy) n++;
    tick();
    new_label = 1'b1;
    #1;
    check_eq("alloc_in_write", alloc_label, 1);
    if (flush_busy) n++;
    @(posedge clk);
    #1;
    new_label = 1'b0;
    count_busy(m);
    n += m;
    check_eq("busy_cycles_stall", n, 7);
    check_eq("busy_fell", flush_busy, 0);
    tick();
    check_eq("deferred_swap", flush_busy, 1);
    wait_drain("deferred");
    lookup(4, 1, "lookup_4_deferred");
    lookup(3, 1, "lookup_3_deferred");
    check_eq("num_after_stall", num_labels, 2);

    // Enable low holds state
    en = 1'b0;
    new_label = 1'b1;
    #1;
    check_eq("en_low_alloc", alloc_label, 0);
    tick();
    new_label = 1'b0;
    check_eq("en_low_num", num_labels, 2);
    en = 1'b1;

    // Async reset aborts an in-flight lookup and restores the table
    lookup_valid = 1'b1;
    lookup_label = 4;
    tick();
    lookup_valid = 1'b0;
    lookup_label = '0;
    reset_n = 1'b0;
    #1;
    check_eq("arst_rvld", resolved_valid, 0);
    check_eq("arst_num", num_labels, 1);
    tick();
    reset_n = 1'b1;
    tick();
    lookup(4, 4, "lookup_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
